// File: rtl/unicone_packet_decoder.sv
// Multi-port serial packet decoder: stages each payload, checks the optional
// trailing checksum, then replays the payload onto the addressed port.
module unicone_packet_decoder #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter logic [3:0]  SYNC_NIBBLE = 4'h5,
    parameter int unsigned CHECKSUM    = 1
) (
    input  logic                  FIFO_clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    input  logic                  rx_idle,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [7:0]            write_data,
    output logic [NUM_PORTS-1:0]  write_en,
    output logic [NUM_PORTS-1:0]  commit,
    output logic                  packet_error,
    output logic [7:0]            error_count,
    output logic                  activity
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_FLAGS, S_PAYLOAD, S_CHECK, S_REPLAY, S_DISCARD
    } state_t;

    state_t                state_q;
    logic [3:0]            port_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [7:0]            sum_q;
    logic                  ovr_q;
    logic [7:0]            mem_q [DEPTH];

    logic [7:0]            sum_d;
    logic [ADDR_WIDTH-1:0] idx_d;
    logic [ADDR_WIDTH-1:0] flen_d;
    logic [ADDR_WIDTH-1:0] len_done_d;
    logic [NUM_PORTS-1:0]  port_oh_d;
    logic                  last_d;
    logic                  drop_d;
    logic                  done_d;

    always_comb begin
        sum_d  = sum_q + rx_data;
        idx_d  = idx_q + ADDR_WIDTH'(1);
        last_d = (idx_q == len_q - ADDR_WIDTH'(1));
        if (rx_data[2])      flen_d = ADDR_WIDTH'(18);
        else if (rx_data[1]) flen_d = ADDR_WIDTH'(6);
        else if (rx_data[0]) flen_d = ADDR_WIDTH'(2);
        else                 flen_d = '0;
        port_oh_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (32'(port_q) == p) port_oh_d[p] = 1'b1;
        end
    end

    // done_d: packet accepted this cycle; drop_d: packet rejected this cycle
    always_comb begin
        drop_d     = 1'b0;
        done_d     = 1'b0;
        len_done_d = len_q;
        case (state_q)
            S_IDLE:
                drop_d = rx_strobe && ((rx_data[7:4] != SYNC_NIBBLE) ||
                                       (32'(rx_data[3:0]) >= NUM_PORTS));
            S_FLAGS: begin
                len_done_d = flen_d;
                if (rx_strobe) done_d = (flen_d == '0) && (CHECKSUM == 0);
                else           drop_d = rx_idle;
            end
            S_PAYLOAD: begin
                if (rx_strobe) done_d = last_d && (CHECKSUM == 0);
                else           drop_d = rx_idle;
            end
            S_CHECK: begin
                if (rx_strobe) begin
                    done_d = (sum_d == '0);
                    drop_d = (sum_d != '0);
                end else begin
                    drop_d = rx_idle;
                end
            end
            S_REPLAY: drop_d = last_d && (ovr_q || rx_strobe);
            default: ;
        endcase
    end

    always_ff @(posedge FIFO_clk) begin
        if (state_q == S_PAYLOAD && rx_strobe) mem_q[idx_q] <= rx_data;
    end

    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            port_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            ovr_q        <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            write_en     <= '0;
            commit       <= '0;
            packet_error <= 1'b0;
            error_count  <= '0;
        end else begin
            write_addr   <= '0;
            write_data   <= '0;
            write_en     <= '0;
            commit       <= '0;
            packet_error <= drop_d;
            if (drop_d && error_count != 8'hFF) error_count <= error_count + 8'd1;

            case (state_q)
                S_IDLE: begin
                    if (rx_strobe) begin
                        port_q  <= rx_data[3:0];
                        sum_q   <= rx_data;
                        state_q <= S_FLAGS;
                    end
                end
                S_FLAGS: begin
                    if (rx_strobe) begin
                        len_q   <= flen_d;
                        sum_q   <= sum_d;
                        idx_q   <= '0;
                        state_q <= (flen_d == '0) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (rx_strobe) begin
                        sum_q <= sum_d;
                        idx_q <= idx_d;
                        if (last_d) state_q <= S_CHECK;
                    end
                end
                S_CHECK: ;
                S_REPLAY: begin
                    if (rx_strobe) ovr_q <= 1'b1;
                    if (last_d) begin
                        commit  <= port_oh_d;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q      <= idx_d;
                        write_en   <= port_oh_d;
                        write_addr <= idx_d;
                        write_data <= mem_q[idx_d];
                    end
                end
                S_DISCARD: if (rx_idle) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // Acceptance presents the first write (or the commit for an empty
            // payload) on the same edge, giving first write_en at T+1.
            if (done_d) begin
                ovr_q <= 1'b0;
                idx_q <= '0;
                if (len_done_d == '0) begin
                    commit  <= port_oh_d;
                    state_q <= S_IDLE;
                end else begin
                    write_en   <= port_oh_d;
                    write_data <= mem_q['0];
                    state_q    <= S_REPLAY;
                end
            end
            if (drop_d) state_q <= rx_idle ? S_IDLE : S_DISCARD;
        end
    end

    assign activity = (|write_en) || (|commit);

endmodule

// File: tb/tb_unicone_packet_decoder.sv
// Randomized bench for unicone_packet_decoder with a per-packet reference model.
module tb_unicone_packet_decoder;
    localparam int NP = 4;
    localparam int AW = 5;
    localparam int CK = 1;

    logic          FIFO_clk = 1'b0;
    logic          reset    = 1'b1;
    logic [7:0]    rx_data  = '0;
    logic          rx_strobe = 1'b0;
    logic          rx_idle  = 1'b1;
    logic [AW-1:0] write_addr;
    logic [7:0]    write_data;
    logic [NP-1:0] write_en;
    logic [NP-1:0] commit;
    logic          packet_error;
    logic [7:0]    error_count;
    logic          activity;

    int     passed = 0;
    int     total  = 0;
    int     cyc    = 0;
    int     inv_bad = 0;
    int     model_err = 0;
    longint obs_q[$];
    longint exp_q[$];

    unicone_packet_decoder #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .SYNC_NIBBLE(4'h5),
        .CHECKSUM   (CK)
    ) dut (
        .FIFO_clk    (FIFO_clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .rx_idle     (rx_idle),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_en    (write_en),
        .commit      (commit),
        .packet_error(packet_error),
        .error_count (error_count),
        .activity    (activity)
    );

    always #5 FIFO_clk = ~FIFO_clk;
    always @(posedge FIFO_clk) cyc <= cyc + 1;

    // event word: cycle | kind (0 write, 1 commit, 2 error) | port | addr | data
    function automatic longint enc(input int c, input int kind, input int port,
                                   input int addr, input int data);
        return (longint'(c) << 32) | (longint'(kind) << 24) | (longint'(port) << 16) |
               (longint'(addr) << 8) | longint'(data);
    endfunction

    always @(negedge FIFO_clk) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                if (write_en[p]) obs_q.push_back(enc(cyc, 0, p, int'(write_addr), int'(write_data)));
                if (commit[p])   obs_q.push_back(enc(cyc, 1, p, 0, 0));
            end
            if (packet_error) obs_q.push_back(enc(cyc, 2, 0, 0, 0));
            if ($countones(write_en) > 1 || $countones(commit) > 1 ||
                ((|write_en) && (|commit)) ||
                (!(|write_en) && (write_addr != '0 || write_data != '0)) ||
                (activity != ((|write_en) || (|commit))))
                inv_bad++;
        end
    end

    task automatic tick();
        @(posedge FIFO_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        rx_data   = b;
        rx_strobe = 1'b1;
        rx_idle   = 1'b0;
        t = cyc;
        tick();
        rx_strobe = 1'b0;
        rx_data   = '0;
    endtask

    task automatic idle_gap(input int n, output int t);
        rx_idle = 1'b1;
        t = cyc;
        repeat (n) tick();
        rx_idle = 1'b0;
    endtask

    function automatic int payload_len(input logic [7:0] flags);
        if (flags[2]) return 18;
        if (flags[1]) return 6;
        if (flags[0]) return 2;
        return 0;
    endfunction

    function automatic void exp_err(input int c);
        exp_q.push_back(enc(c, 2, 0, 0, 0));
        if (model_err < 255) model_err++;
    endfunction

    // Expected events for one packet given byte times and the cycle idle rose.
    function automatic void model(input logic [7:0] pkt[$], input int t[$], input int idle_t);
        logic [7:0] b0, fl, s;
        int port, n, need;
        b0 = pkt[0];
        port = int'(b0[3:0]);
        if (b0[7:4] != 4'h5 || port >= NP) begin exp_err(t[0] + 1); return; end
        if (pkt.size() < 2) begin exp_err(idle_t + 1); return; end
        fl = pkt[1];
        n = payload_len(fl);
        need = 2 + n + CK;
        if (pkt.size() < need) begin exp_err(idle_t + 1); return; end
        s = '0;
        for (int i = 0; i < need; i++) s = s + pkt[i];
        if (CK != 0 && s != 8'h00) begin exp_err(t[need-1] + 1); return; end
        for (int i = 0; i < n; i++)
            exp_q.push_back(enc(t[need-1] + 1 + i, 0, port, i, int'(pkt[2+i])));
        exp_q.push_back(enc(t[need-1] + 1 + n, 1, port, 0, 0));
    endfunction

    task automatic make_pkt(input int port, input logic [7:0] flags, input bit bad_ck,
                            input bit seq, output logic [7:0] pkt[$]);
        logic [7:0] s, b;
        int n;
        pkt.delete();
        pkt.push_back({4'h5, 4'(port)});
        pkt.push_back(flags);
        n = payload_len(flags);
        for (int i = 0; i < n; i++) begin
            b = seq ? 8'((i + 1) * 17) : 8'($urandom);
            pkt.push_back(b);
        end
        if (CK != 0) begin
            s = '0;
            foreach (pkt[i]) s = s + pkt[i];
            s = 8'h00 - s;
            if (bad_ck) s = s + 8'h01;
            pkt.push_back(s);
        end
    endtask

    task automatic send_pkt(input logic [7:0] pkt[$], input int maxgap, output int t[$]);
        int tt;
        t.delete();
        foreach (pkt[i]) begin
            send_byte(pkt[i], tt);
            t.push_back(tt);
            repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic check_events(input string name);
        obs_q.sort();
        exp_q.sort();
        total++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL %s event count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        else passed++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL %s event[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
            else passed++;
        end
        total++;
        if (error_count !== 8'(model_err))
            $display("FAIL %s error_count: got %0d expected %0d", name, error_count, model_err);
        else passed++;
        total++;
        if (inv_bad !== 0)
            $display("FAIL %s output encoding: got %0d bad cycles expected 0", name, inv_bad);
        else passed++;
        obs_q.delete();
        exp_q.delete();
        inv_bad = 0;
    endtask

    task automatic run_pkt(input logic [7:0] pkt[$], input int maxgap, input string name);
        int t[$];
        int it;
        send_pkt(pkt, maxgap, t);
        idle_gap(2, it);
        repeat (25) tick();
        model(pkt, t, it);
        check_events(name);
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({write_en, commit, write_addr, write_data, packet_error, error_count, activity} !== '0)
            $display("FAIL reset outputs: got %h expected 0",
                     {write_en, commit, write_addr, write_data, packet_error, error_count, activity});
        else passed++;
        repeat (2) @(posedge FIFO_clk);
        #1 reset = 1'b0;
        tick();
        rx_idle = 1'b0;
    endtask

    task automatic test_good();
        logic [7:0] pkt[$];
        make_pkt(2, 8'h02, 1'b0, 1'b1, pkt);
        run_pkt(pkt, 0, "good_port2");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] pkt[$];
        make_pkt(2, 8'h02, 1'b1, 1'b1, pkt);
        run_pkt(pkt, 0, "bad_checksum");
    endtask

    task automatic test_bad_sync();
        logic [7:0] pkt[$];
        pkt = '{8'h63, 8'h02, 8'h11, 8'h22};
        run_pkt(pkt, 1, "bad_sync");
        make_pkt(0, 8'h01, 1'b0, 1'b0, pkt);
        run_pkt(pkt, 1, "after_bad_sync");
    endtask

    task automatic test_bad_port();
        logic [7:0] pkt[$];
        make_pkt(7, 8'h02, 1'b0, 1'b0, pkt);
        run_pkt(pkt, 0, "bad_port");
    endtask

    task automatic test_truncation();
        logic [7:0] pkt[$];
        make_pkt(1, 8'h04, 1'b0, 1'b0, pkt);
        while (pkt.size() > 5) void'(pkt.pop_back());
        run_pkt(pkt, 0, "truncated");
        make_pkt(3, 8'h04, 1'b0, 1'b0, pkt);
        run_pkt(pkt, 1, "full_20");
    endtask

    task automatic test_zero_len();
        logic [7:0] pkt[$];
        make_pkt(3, 8'h00, 1'b0, 1'b0, pkt);
        run_pkt(pkt, 0, "zero_len");
        make_pkt(1, 8'hF8, 1'b0, 1'b0, pkt);
        run_pkt(pkt, 0, "zero_len_hiflags");
    endtask

    task automatic test_overrun();
        logic [7:0] pkt[$];
        int t[$];
        int tt, it, k;
        for (int r = 0; r < 4; r++) begin
            make_pkt(r % NP, 8'h02, 1'b0, 1'b0, pkt);
            send_pkt(pkt, 0, t);
            k = int'($urandom_range(0, 5));
            repeat (k) tick();
            send_byte(8'($urandom), tt);
            repeat (10) tick();
            idle_gap(2, it);
            repeat (5) tick();
            model(pkt, t, it);
            exp_err(t[t.size()-1] + 1 + 6);
            check_events("overrun");
        end
    endtask

    task automatic test_random();
        logic [7:0] pkt[$];
        int port, len;
        bit bad;
        for (int r = 0; r < 40; r++) begin
            port = int'($urandom_range(0, NP + 1));
            bad  = ($urandom_range(0, 5) == 0);
            make_pkt(port, 8'($urandom), bad, 1'b0, pkt);
            if ($urandom_range(0, 7) == 0) begin
                len = int'($urandom_range(1, pkt.size() - 1));
                while (pkt.size() > len) void'(pkt.pop_back());
            end
            run_pkt(pkt, 2, "random");
        end
    endtask

    task automatic test_saturation();
        int t, it;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h63, t);
            exp_err(t + 1);
            idle_gap(1, it);
        end
        repeat (3) tick();
        total++;
        if (error_count !== 8'hFF)
            $display("FAIL saturation: got %0d expected 255", error_count);
        else passed++;
        check_events("saturation");
    endtask

    task automatic test_reset_mid_replay();
        logic [7:0] pkt[$];
        int t[$];
        make_pkt(1, 8'h04, 1'b0, 1'b0, pkt);
        send_pkt(pkt, 0, t);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({write_en, commit, write_addr, write_data, packet_error, error_count, activity} !== '0)
            $display("FAIL reset_mid_replay outputs: got %h expected 0",
                     {write_en, commit, write_addr, write_data, packet_error, error_count, activity});
        else passed++;
        total++;
        if (obs_q.size() !== 3)
            $display("FAIL reset_mid_replay writes before reset: got %0d expected 3", obs_q.size());
        else passed++;
        tick();
        tick();
        obs_q.delete();
        exp_q.delete();
        inv_bad = 0;
        model_err = 0;
        reset = 1'b0;
        repeat (30) tick();
        check_events("reset_mid_replay");
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_checksum();
        test_bad_sync();
        test_bad_port();
        test_truncation();
        test_zero_len();
        test_overrun();
        test_random();
        test_saturation();
        test_reset_mid_replay();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
